// File: rtl/delay_line_pkg.sv
// delay_line_pkg: FSM encoding and SRAM strobe idle levels for delay_line_sram
package delay_line_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_RD_SETUP, S_RD_WAIT, S_RD_DONE
  } state_t;
  localparam logic CE_N_IDLE = 1'b0;
  localparam logic OE_N_IDLE = 1'b1;
  localparam logic WE_N_IDLE = 1'b1;
  localparam logic BE_N_IDLE = 1'b0;
endpackage

// File: rtl/sram_phy_ctrl.sv
// sram_phy_ctrl: registers SRAM address/data/strobes to the pins and captures read data
module sram_phy_ctrl
  import delay_line_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 18,
  parameter logic [AW-1:0] RST_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [AW-1:0] addr_d,
  input  logic [DW-1:0] dq_d,
  input  logic          dq_oe_d,
  input  logic          oe_n_d,
  input  logic          we_n_d,
  input  logic          cap,
  input  logic          finish_d,
  input  logic [DW-1:0] sram_dq_in,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_out,
  output logic          sram_dq_oe,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          sram_ub_n,
  output logic          sram_lb_n,
  output logic [DW-1:0] data_out,
  output logic          read_finish
);
  assign sram_ce_n = CE_N_IDLE;
  assign sram_ub_n = BE_N_IDLE;
  assign sram_lb_n = BE_N_IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_addr   <= RST_ADDR;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_oe_n   <= OE_N_IDLE;
      sram_we_n   <= WE_N_IDLE;
      data_out    <= '0;
      read_finish <= 1'b0;
    end else begin
      if (ld) begin
        sram_addr   <= addr_d;
        sram_dq_out <= dq_d;
      end
      sram_dq_oe  <= dq_oe_d;
      sram_oe_n   <= oe_n_d;
      sram_we_n   <= we_n_d;
      if (cap) data_out <= sram_dq_in;
      read_finish <= finish_d;
    end
  end
endmodule

// File: rtl/delay_line_sram.sv
// delay_line_sram: circular audio delay line in external async SRAM serving delayed-sample reads.
// Define DELAY_LINE_CLEAR_EN to zero the whole buffer after reset before accepting traffic.
module delay_line_sram
  import delay_line_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int BUF_AW     = 13,
  parameter int SRAM_AW    = 18,
  parameter int BASE_ADDR  = 0,
  parameter int ACC_CYC    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sram_rd,
  input  logic [ADDR_WIDTH-1:0] sram_offset,
  output logic [DATA_WIDTH-1:0] sram_data_in,
  output logic                  sram_read_finish,
  output logic                  ready,
  output logic                  overrun,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dq_out,
  input  logic [DATA_WIDTH-1:0] sram_dq_in,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);
  localparam logic [7:0] ACC_LAST = 8'(ACC_CYC - 1);
  state_t state, state_n;
  logic [7:0] cnt;
  logic [BUF_AW-1:0] wr_ptr, wr_ptr_n, d_q, slot;
  logic [DATA_WIDTH-1:0] sample_q;
  logic wr_pend, rd_pend, clr, last, ld;
`ifdef DELAY_LINE_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
  always_ff @(posedge clk) begin
    if (!rst) clr <= 1'b1;
    else if (state == S_WR_HOLD && wr_ptr == '1) clr <= 1'b0;
  end
`else
  localparam state_t RST_STATE = S_IDLE;
  assign clr = 1'b0;
`endif
  assign last  = cnt == ACC_LAST;
  assign ready = !clr;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     state_n = wr_pend ? S_WR_SETUP : rd_pend ? S_RD_SETUP : S_IDLE;
      S_CLEAR:    state_n = S_WR_PULSE;
      S_WR_SETUP: state_n = S_WR_PULSE;
      S_WR_PULSE: state_n = last ? S_WR_HOLD : S_WR_PULSE;
      S_WR_HOLD:  state_n = (clr && wr_ptr != '1) ? S_CLEAR : rd_pend ? S_RD_SETUP : S_IDLE;
      S_RD_SETUP: state_n = S_RD_WAIT;
      S_RD_WAIT:  state_n = last ? S_RD_DONE : S_RD_WAIT;
      S_RD_DONE:  state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end
  // slot uses the post-update pointer so a write finishing this cycle is visible to the read
  assign wr_ptr_n = (state == S_WR_HOLD) ? wr_ptr + BUF_AW'(1) : wr_ptr;
  assign slot     = (state_n == S_RD_SETUP) ? wr_ptr_n - BUF_AW'(1) - d_q : wr_ptr_n;
  assign ld       = state_n != state && (state_n == S_WR_SETUP || state_n == S_CLEAR || state_n == S_RD_SETUP);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RST_STATE;
      cnt      <= '0;
      wr_ptr   <= '0;
      wr_pend  <= 1'b0;
      rd_pend  <= 1'b0;
      sample_q <= '0;
      d_q      <= '0;
      overrun  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= (state_n == state) ? cnt + 8'd1 : 8'd0;
      wr_ptr  <= wr_ptr_n;
      wr_pend <= sample_valid | (wr_pend & !(state == S_WR_HOLD && !clr));
      rd_pend <= rd_pend ? state != S_RD_DONE : sram_rd;
      if (sample_valid) sample_q <= sample_in;
      if (sram_rd && !rd_pend) d_q <= BUF_AW'(sram_offset >> 1);
      overrun <= overrun | (sample_valid & wr_pend) | (sram_rd & rd_pend);
    end
  end
  sram_phy_ctrl #(.DW(DATA_WIDTH), .AW(SRAM_AW), .RST_ADDR(SRAM_AW'(BASE_ADDR))) u_phy (
    .clk(clk),
    .rst(rst),
    .ld(ld),
    .addr_d(SRAM_AW'(BASE_ADDR) + SRAM_AW'(slot)),
    .dq_d(clr ? '0 : sample_q),
    .dq_oe_d(state_n == S_CLEAR || state_n == S_WR_SETUP || state_n == S_WR_PULSE),
    .oe_n_d(state_n != S_RD_WAIT),
    .we_n_d(state_n != S_WR_PULSE),
    .cap(state == S_RD_WAIT && state_n == S_RD_DONE),
    .finish_d(state_n == S_RD_DONE),
    .sram_dq_in(sram_dq_in),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n),
    .data_out(sram_data_in),
    .read_finish(sram_read_finish)
  );
endmodule

// File: tb/tb_delay_line_sram.sv
// tb_delay_line_sram: directed checks of delay_line_sram against a behavioural async SRAM
module tb_delay_line_sram;
  localparam int DW = 16, AW = 13, BAW = 4, SAW = 18, ACC = 2, DEPTH = 16;
  logic clk = 0, rst = 0, sample_valid = 0, sram_rd = 0;
  logic [DW-1:0] sample_in = '0, sram_data_in, sram_dq_out, sram_dq_in;
  logic [AW-1:0] sram_offset = '0;
  logic sram_read_finish, ready, overrun, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [SAW-1:0] sram_addr, last_wr_addr;
  logic [DW-1:0] mem [0:1023];
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  delay_line_sram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_AW(BAW), .SRAM_AW(SAW), .BASE_ADDR(0), .ACC_CYC(ACC)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in), .sram_rd(sram_rd),
    .sram_offset(sram_offset), .sram_data_in(sram_data_in), .sram_read_finish(sram_read_finish),
    .ready(ready), .overrun(overrun), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n));

  always @(posedge clk) if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
    mem[sram_addr[9:0]] <= sram_dq_out;
    last_wr_addr <= sram_addr;
  end
  assign sram_dq_in = !sram_oe_n ? mem[sram_addr[9:0]] : 16'h0BAD;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 0; sample_valid = 0; sram_rd = 0;
    tick; tick;
    rst = 1;
`ifdef DELAY_LINE_CLEAR_EN
    for (int i = 0; i < 200 && !ready; i++) tick;
`endif
  endtask

  task automatic write_sample(input logic [DW-1:0] v);
    sample_valid = 1; sample_in = v;
    tick;
    sample_valid = 0;
    repeat (6) tick;
  endtask

  task automatic do_read(input logic [AW-1:0] off, input logic also_wr, input logic [DW-1:0] wv,
                         output logic [DW-1:0] data, output int lat);
    sram_rd = 1; sram_offset = off; sample_valid = also_wr; sample_in = wv;
    tick;
    sram_rd = 0; sample_valid = 0; lat = 1;
    while (!sram_read_finish && lat < 40) begin tick; lat++; end
    data = sram_data_in;
    if (!sram_read_finish) begin
      checks++; lat = -1;
      $display("FAIL read_timeout: no sram_read_finish within 40 cycles, offset %0d", off);
    end
    tick;
  endtask

  task automatic test_reset;
    logic exp_ready;
`ifdef DELAY_LINE_CLEAR_EN
    exp_ready = 0;
`else
    exp_ready = 1;
`endif
    rst = 0; tick;
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 6'b011000)
      $display("FAIL reset_strobes: got %b want 011000", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}); else passed++;
    checks++; if (sram_addr !== '0) $display("FAIL reset_addr: got %h want 0", sram_addr); else passed++;
    checks++; if ({sram_read_finish, overrun} !== 2'b00 || sram_data_in !== '0)
      $display("FAIL reset_outputs: finish/overrun %b data %h want 00 0000", {sram_read_finish, overrun}, sram_data_in); else passed++;
    checks++; if (ready !== exp_ready) $display("FAIL reset_ready: got %b want %b", ready, exp_ready); else passed++;
    do_reset;
  endtask

  task automatic test_basic;
    logic [DW-1:0] d; int lat;
    for (int i = 1; i <= 5; i++) write_sample(DW'(i));
    do_read(0, 0, 0, d, lat);
    checks++; if (d !== 16'h0005) $display("FAIL basic_newest: got %h want 0005", d); else passed++;
    checks++; if (lat !== 5) $display("FAIL basic_latency: got %0d want 5", lat); else passed++;
    checks++; if (sram_read_finish !== 1'b0) $display("FAIL basic_pulse: finish %b want 0", sram_read_finish); else passed++;
    do_read(8, 0, 0, d, lat);
    checks++; if (d !== 16'h0001) $display("FAIL basic_d4: got %h want 0001", d); else passed++;
    do_read(9, 0, 0, d, lat);
    checks++; if (d !== 16'h0001) $display("FAIL basic_odd_offset: got %h want 0001", d); else passed++;
  endtask

  task automatic test_raw;
    logic [DW-1:0] d; int lat;
    do_read(0, 1, 16'hABCD, d, lat);
    checks++; if (d !== 16'hABCD) $display("FAIL raw_data: got %h want abcd", d); else passed++;
    checks++; if (lat !== 9) $display("FAIL raw_latency: got %0d want 9", lat); else passed++;
  endtask

  task automatic test_wrap;
    logic [DW-1:0] d; int lat;
    do_reset;
    for (int i = 0; i < DEPTH + 3; i++) write_sample(DW'(i));
    do_read(0, 0, 0, d, lat);
    checks++; if (d !== 16'd18) $display("FAIL wrap_newest: got %h want 0012", d); else passed++;
    do_read(AW'(2 * (DEPTH - 1)), 0, 0, d, lat);
    checks++; if (d !== 16'd3) $display("FAIL wrap_oldest: got %h want 0003", d); else passed++;
    do_read(AW'(2 * DEPTH), 0, 0, d, lat);
    checks++; if (d !== 16'd18) $display("FAIL wrap_alias: got %h want 0012", d); else passed++;
  endtask

  task automatic test_overrun;
    logic [DW-1:0] d; int lat;
    checks++; if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b want 0", overrun); else passed++;
    sram_rd = 1; sram_offset = 0; tick;
    sram_rd = 0; tick; tick;
    sample_valid = 1; sample_in = 16'h1111; tick;
    sample_in = 16'h2222; tick;
    sample_valid = 0;
    checks++; if (sram_read_finish !== 1'b1 || sram_data_in !== 16'd18)
      $display("FAIL overrun_read: finish %b data %h want 1 0012", sram_read_finish, sram_data_in); else passed++;
    checks++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun); else passed++;
    repeat (7) tick;
    do_read(0, 0, 0, d, lat);
    checks++; if (d !== 16'h2222) $display("FAIL overrun_second: got %h want 2222", d); else passed++;
    do_read(2, 0, 0, d, lat);
    checks++; if (d !== 16'd18) $display("FAIL overrun_first_lost: got %h want 0012", d); else passed++;
    checks++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun); else passed++;
  endtask

  task automatic test_reset_mid_write;
    logic [DW-1:0] d; int lat;
    sample_valid = 1; sample_in = 16'h5555; tick;
    sample_valid = 0; tick; tick;
    checks++; if (sram_we_n !== 1'b0) $display("FAIL midwr_pulse: we_n %b want 0", sram_we_n); else passed++;
    rst = 0; tick;
    checks++; if ({sram_we_n, sram_dq_oe, sram_read_finish, overrun} !== 4'b1000)
      $display("FAIL midwr_abort: we_n/oe/finish/overrun %b want 1000", {sram_we_n, sram_dq_oe, sram_read_finish, overrun}); else passed++;
    do_reset;
    write_sample(16'h7777);
    checks++; if (last_wr_addr !== '0) $display("FAIL midwr_ptr: write addr %h want 0", last_wr_addr); else passed++;
    do_read(0, 0, 0, d, lat);
    checks++; if (d !== 16'h7777) $display("FAIL midwr_read: got %h want 7777", d); else passed++;
  endtask

  task automatic test_read_drop;
    int fin;
    do_reset;
    fin = 0;
    sram_rd = 1; sram_offset = 0; tick;
    sram_offset = 4; tick;
    sram_rd = 0;
    for (int i = 0; i < 15; i++) begin fin += int'(sram_read_finish); tick; end
    checks++; if (fin !== 1) $display("FAIL drop_finishes: got %0d want 1", fin); else passed++;
    checks++; if (overrun !== 1'b1) $display("FAIL drop_overrun: got %b want 1", overrun); else passed++;
  endtask

`ifdef DELAY_LINE_CLEAR_EN
  task automatic test_clear;
    logic [DW-1:0] d; int lat, n;
    rst = 0; tick;
    rst = 1; n = 0;
    while (!ready && n < 200) begin n++; tick; end
    checks++; if (n !== DEPTH * (ACC + 2)) $display("FAIL clear_cycles: got %0d want %0d", n, DEPTH * (ACC + 2)); else passed++;
    do_read(AW'(2 * (DEPTH - 1)), 0, 0, d, lat);
    checks++; if (d !== 16'h0000) $display("FAIL clear_slot0: got %h want 0000", d); else passed++;
    do_read(6, 0, 0, d, lat);
    checks++; if (d !== 16'h0000) $display("FAIL clear_slot12: got %h want 0000", d); else passed++;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_raw;
    test_wrap;
    test_overrun;
    test_reset_mid_write;
    test_read_drop;
`ifdef DELAY_LINE_CLEAR_EN
    test_clear;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
